// File: rtl/rotate_pkg.sv
// Shared types for the rotate register and its sequencing controller,
// plus reference rotate functions used by the testbench model.
package rotate_pkg;

   typedef enum logic [1:0] {
      CMD_HOLD = 2'b00,
      CMD_LOAD = 2'b01,
      CMD_ROR  = 2'b10,
      CMD_ROL  = 2'b11
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      SHIFT,
      DONE,
      RESP
   } state_t;

   // Rotate the low n bits of v right by amt positions (bit i takes bit i+1).
   function automatic logic [31:0] ror_n(input logic [31:0] v,
                                         input int unsigned n,
                                         input int unsigned amt);
      logic [31:0] cur;
      logic [31:0] nxt;
      cur = v;
      for (int unsigned k = 0; k < amt; k++) begin
         nxt = '0;
         for (int unsigned i = 0; i < n; i++)
            nxt[i] = cur[(i + 1) % n];
         cur = nxt;
      end
      return cur;
   endfunction

   // Rotate the low n bits of v left by amt positions (bit i takes bit i-1).
   function automatic logic [31:0] rol_n(input logic [31:0] v,
                                         input int unsigned n,
                                         input int unsigned amt);
      logic [31:0] cur;
      logic [31:0] nxt;
      cur = v;
      for (int unsigned k = 0; k < amt; k++) begin
         nxt = '0;
         for (int unsigned i = 0; i < n; i++)
            nxt[i] = cur[(i + n - 1) % n];
         cur = nxt;
      end
      return cur;
   endfunction

endpackage

// File: rtl/rotate.sv
// N-bit rotate register: hold, parallel load, rotate right or left by one.
// No reset; q is undefined until the first load.
module rotate
   import rotate_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic         clock,
   input  cmd_t         cmd,
   input  logic [N-1:0] p,
   output logic [N-1:0] q
);

   // Register update selected by the command code.
   always_ff @(posedge clock) begin
      case (cmd)
         CMD_LOAD: q <= p;
         CMD_ROR:  q <= {q[0], q[N-1:1]};
         CMD_ROL:  q <= {q[N-2:0], q[N-1]};
         default:  q <= q;
      endcase
   end

endmodule

// File: rtl/rotate_seq_ctrl.sv
// Sequencer for the rotate register: accepts one request per handshake,
// loads the value, issues count rotate steps, captures q and returns it.
// All outputs decode from registered state only.
module rotate_seq_ctrl
   import rotate_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned CW = $clog2(N) + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [N-1:0]  req_data,
   input  logic          req_dir,
   input  logic [CW-1:0] req_count,
   output cmd_t          cmd,
   output logic [N-1:0]  p,
   input  logic [N-1:0]  q_in,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [N-1:0]  rsp_data
);

   state_t        state;
   state_t        state_nx;
   logic [N-1:0]  data_q;
   logic          dir_q;
   logic [CW-1:0] remaining;

   // State register, request latches, rotate counter and response capture.
   // The count is latched straight into the counter at accept, so LOAD can
   // test it for zero without a separate count register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         data_q    <= '0;
         dir_q     <= 1'b0;
         remaining <= '0;
         rsp_data  <= '0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  data_q    <= req_data;
                  dir_q     <= req_dir;
                  remaining <= req_count;
               end
            end
            SHIFT:   remaining <= remaining - CW'(1);
            DONE:    rsp_data  <= q_in;
            default: ;
         endcase
      end
   end

   // Next-state selection and output decode from the current state.
   always_comb begin
      state_nx  = state;
      cmd       = CMD_HOLD;
      req_ready = 1'b0;
      rsp_valid = 1'b0;
      p         = data_q;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nx = LOAD;
         end
         LOAD: begin
            cmd      = CMD_LOAD;
            state_nx = (remaining == '0) ? DONE : SHIFT;
         end
         SHIFT: begin
            cmd = dir_q ? CMD_ROL : CMD_ROR;
            if (remaining == CW'(1)) state_nx = DONE;
         end
         DONE: state_nx = RESP;
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule

// File: tb/tb_rotate_seq_ctrl.sv
// Bench for rotate_seq_ctrl driving a rotate register instance.
module tb_rotate_seq_ctrl;
   import rotate_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned CW = 3;

   logic          clock;
   logic          reset_n;
   logic          req_valid;
   logic          req_ready;
   logic [N-1:0]  req_data;
   logic          req_dir;
   logic [CW-1:0] req_count;
   cmd_t          cmd;
   logic [N-1:0]  p;
   logic [N-1:0]  q;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [N-1:0]  rsp_data;

   int errors  = 0;
   int checks  = 0;
   int acc     = 0;
   int rsps    = 0;
   int dropped = 0;
   int cmd_x   = 0;

   logic [N-1:0] expq[$];
   int           latq[$];
   cmd_t         trace[$];

   rotate_seq_ctrl #(.N(N), .CW(CW)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_dir   (req_dir),
      .req_count (req_count),
      .cmd       (cmd),
      .p         (p),
      .q_in      (q),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data)
   );

   rotate #(.N(N)) rot (
      .clock (clock),
      .cmd   (cmd),
      .p     (p),
      .q     (q)
   );

   initial clock = 1'b0;
   always #10 clock = ~clock;

   // Handshake counters and unknown-command monitor.
   always @(posedge clock) begin
      if (reset_n && req_valid && req_ready) acc++;
      if (reset_n && rsp_valid && rsp_ready) rsps++;
   end

   always @(negedge clock) begin
      if (reset_n && $isunknown(cmd)) cmd_x++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [N-1:0] d, input logic dir, input logic [CW-1:0] cnt);
      logic [31:0] r;
      r = dir ? rol_n(32'(d), N, int'(cnt)) : ror_n(32'(d), N, int'(cnt));
      expq.push_back(r[N-1:0]);
      latq.push_back(int'(cnt) + 3);
   endtask

   // Present a request, wait for acceptance, record the expected result,
   // then scramble the request inputs to show they are not re-sampled.
   task automatic start_req(input logic [N-1:0] d, input logic dir, input logic [CW-1:0] cnt);
      int n;
      trace.delete();
      @(negedge clock);
      req_data  = d;
      req_dir   = dir;
      req_count = cnt;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check("accept_wait", 32'(req_ready), 32'd1);
      @(posedge clock);
      push_exp(d, dir, cnt);
      #1;
      req_valid = 1'b0;
      req_data  = N'($urandom);
      req_dir   = 1'($urandom);
      req_count = CW'($urandom);
   endtask

   // Wait for the response, check latency and data, optionally stall
   // rsp_ready for hold cycles, then complete the handshake.
   task automatic finish_rsp(input int hold);
      int          lat;
      int          lat_exp;
      logic [N-1:0] exp;
      lat_exp = (latq.size() > 0) ? latq.pop_front() : -1;
      exp     = (expq.size() > 0) ? expq.pop_front() : 'x;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
         trace.push_back(cmd);
      end while (!rsp_valid && lat < 40);
      check("latency", 32'(lat), 32'(lat_exp));
      for (int i = 0; i < hold; i++) begin
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rsp_data", 32'(rsp_data), 32'(exp));
         check("hold_cmd", 32'(cmd), 32'(CMD_HOLD));
         check("hold_req_ready", 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      rsp_ready = 1'b1;
      check("rsp_data", 32'(rsp_data), 32'(exp));
      @(posedge clock);
      #1;
      rsp_ready = 1'b0;
   endtask

   initial begin
      int n;
      int bad;
      logic [N-1:0] d;
      logic         dir;
      logic [CW-1:0] cnt;

      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_data  = '0;
      req_dir   = 1'b0;
      req_count = '0;
      rsp_ready = 1'b0;

      #25;
      check("reset_cmd", 32'(cmd), 32'(CMD_HOLD));
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_data", 32'(rsp_data), 32'd0);
      check("reset_p", 32'(p), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;

      // Basic right rotate by one and its command trace.
      start_req(4'b0001, 1'b0, 3'd1);
      finish_rsp(0);
      check("trace0_load", 32'(trace[0]), 32'(CMD_LOAD));
      check("trace1_ror", 32'(trace[1]), 32'(CMD_ROR));
      check("trace2_hold", 32'(trace[2]), 32'(CMD_HOLD));

      // Left rotate by three, and a zero-count request.
      start_req(4'b0001, 1'b1, 3'd3);
      finish_rsp(0);
      start_req(4'b1011, 1'b0, 3'd0);
      finish_rsp(0);
      bad = 0;
      foreach (trace[i]) if (trace[i] == CMD_ROR || trace[i] == CMD_ROL) bad++;
      check("count0_no_rotate", 32'(bad), 32'd0);

      // Counts at and beyond the width wrap around.
      start_req(4'b0001, 1'b0, 3'd4);
      finish_rsp(0);
      start_req(4'b0001, 1'b0, 3'd5);
      finish_rsp(0);
      start_req(4'b0001, 1'b1, 3'd7);
      finish_rsp(0);

      // Response stalled for five cycles with a new request waiting.
      start_req(4'b0110, 1'b1, 3'd2);
      req_data  = 4'b0011;
      req_dir   = 1'b0;
      req_count = 3'd1;
      req_valid = 1'b1;
      finish_rsp(5);
      @(negedge clock);
      check("held_req_ready", 32'(req_ready), 32'd1);
      check("held_not_accepted", 32'(cmd), 32'(CMD_HOLD));
      @(posedge clock);
      push_exp(4'b0011, 1'b0, 3'd1);
      trace.delete();
      #1;
      req_valid = 1'b0;
      check("held_accept_load", 32'(cmd), 32'(CMD_LOAD));
      finish_rsp(0);

      // Asynchronous reset while rotating, then a clean request.
      start_req(4'b0001, 1'b0, 3'd5);
      n = 0;
      while (cmd != CMD_ROR && n < 20) begin
         @(negedge clock);
         n++;
      end
      check("reached_shift", 32'(cmd), 32'(CMD_ROR));
      #3;
      reset_n = 1'b0;
      #1;
      check("midreset_cmd", 32'(cmd), 32'(CMD_HOLD));
      check("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("midreset_req_ready", 32'(req_ready), 32'd1);
      check("midreset_p", 32'(p), 32'd0);
      expq.delete();
      latq.delete();
      dropped = 1;
      @(negedge clock);
      reset_n = 1'b1;
      start_req(4'b1000, 1'b1, 3'd2);
      finish_rsp(0);

      // Back-to-back random requests against the reference model.
      for (int k = 0; k < 200; k++) begin
         d   = N'($urandom);
         dir = 1'($urandom);
         cnt = CW'($urandom_range(0, 7));
         start_req(d, dir, cnt);
         finish_rsp(0);
      end

      @(negedge clock);
      check("cmd_never_x", 32'(cmd_x), 32'd0);
      check("rsp_vs_accept", 32'(rsps), 32'(acc - dropped));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
